// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file: NR combinational read ports, two write
// ports (port 1 has priority), optional hardwired zero register, write-to-read bypass
// and a sequenced clear engine that zeroes one register per cycle.
module reg_file_mp #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NR       = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               write0,
  input  logic [AW-1:0]      write_addr0,
  input  logic [XLEN-1:0]    write_data0,
  input  logic               write1,
  input  logic [AW-1:0]      write_addr1,
  input  logic [XLEN-1:0]    write_data1,
  input  logic [NR*AW-1:0]   addr_rd,
  output logic [NR*XLEN-1:0] out_rd,
  input  logic               clear,
  output logic               busy
);

  typedef enum logic {StIdle, StClear} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] mem_d [DEPTH];
  logic            idle;
  logic            we0, we1;
  logic [AW-1:0]   rd_addr;

  // Legal target: inside the array and not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    logic in_range;
    in_range = ({1'b0, a} < (AW + 1)'(DEPTH));
    return in_range && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign idle = (state_q == StIdle);
  assign busy = (state_q == StClear);
  assign we0  = write0 && idle && addr_ok(write_addr0);
  assign we1  = write1 && idle && addr_ok(write_addr1);

  always_comb begin
    mem_d   = mem_q;
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        // Port 1 is applied last so it wins a same-address collision.
        if (we0) mem_d[write_addr0] = write_data0;
        if (we1) mem_d[write_addr1] = write_data1;
        if (clear) begin
          state_d = StClear;
          idx_d   = '0;
        end
      end
      StClear: begin
        mem_d[idx_q] = '0;
        idx_d        = idx_q + 1'b1;
        if (idx_q == AW'(DEPTH - 1)) begin
          state_d = StIdle;
          idx_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Reads are held at zero during reset so a bypassed write cannot leak through.
  always_comb begin
    out_rd  = '0;
    rd_addr = '0;
    for (int i = 0; i < NR; i++) begin
      rd_addr = addr_rd[i*AW +: AW];
      if (!rst && addr_ok(rd_addr)) begin
        if ((BYPASS != 0) && we1 && (rd_addr == write_addr1)) begin
          out_rd[i*XLEN +: XLEN] = write_data1;
        end else if ((BYPASS != 0) && we0 && (rd_addr == write_addr0)) begin
          out_rd[i*XLEN +: XLEN] = write_data0;
        end else begin
          out_rd[i*XLEN +: XLEN] = mem_q[rd_addr];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: dut_a uses the default build, dut_b is DEPTH=24,
// NR=4 with the zero register and bypass disabled. Both share write/clear stimulus.
module tb_reg_file_mp;

  typedef struct packed {
    logic [3:0]  kind;   // 0: dut_a port, 1: dut_b port, 2: dut_a busy
    logic [3:0]  port;
    logic [31:0] exp;
    logic [15:0] id;
  } entry_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         write0, write1, clear;
  logic [4:0]   wa0, wa1;
  logic [31:0]  wd0, wd1;
  logic [9:0]   rda;
  logic [19:0]  rdb;
  logic [63:0]  out_a;
  logic [127:0] out_b;
  logic         busy_a, busy_b;

  entry_t sb[$];
  int     vectors = 0;
  int     miscompares = 0;

  always #5 clk = ~clk;

  reg_file_mp u_dut_a (
    .clk(clk), .rst(rst),
    .write0(write0), .write_addr0(wa0), .write_data0(wd0),
    .write1(write1), .write_addr1(wa1), .write_data1(wd1),
    .addr_rd(rda), .out_rd(out_a), .clear(clear), .busy(busy_a)
  );

  reg_file_mp #(
    .XLEN(32), .DEPTH(24), .NR(4), .ZERO_REG(0), .BYPASS(0)
  ) u_dut_b (
    .clk(clk), .rst(rst),
    .write0(write0), .write_addr0(wa0), .write_data0(wd0),
    .write1(write1), .write_addr1(wa1), .write_data1(wd1),
    .addr_rd(rdb), .out_rd(out_b), .clear(clear), .busy(busy_b)
  );

  // Monitor: outputs are combinational, so every negedge presents a result.
  always @(negedge clk) begin
    entry_t      e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        4'd0:    act = out_a[e.port*32 +: 32];
        4'd1:    act = out_b[e.port*32 +: 32];
        default: act = {31'b0, busy_a};
      endcase
      vectors++;
      if (act !== e.exp) begin
        miscompares++;
        $display("FAIL chk%0d: got %h, want %h", e.id, act, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int port, input logic [31:0] exp, input int id);
    entry_t e;
    e.kind = kind[3:0];
    e.port = port[3:0];
    e.exp  = exp;
    e.id   = id[15:0];
    sb.push_back(e);
  endtask

  task automatic rd_a(input int p, input int a, input logic [31:0] exp, input int id);
    rda[p*5 +: 5] = a[4:0];
    push(0, p, exp, id);
  endtask

  task automatic rd_b(input int p, input int a, input logic [31:0] exp, input int id);
    rdb[p*5 +: 5] = a[4:0];
    push(1, p, exp, id);
  endtask

  task automatic wr(input logic e0, input int a0, input logic [31:0] d0,
                    input logic e1, input int a1, input logic [31:0] d1);
    write0 = e0; wa0 = a0[4:0]; wd0 = d0;
    write1 = e1; wa1 = a1[4:0]; wd1 = d1;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; rda = '0; rdb = '0;
    wr(1'b0, 0, 0, 1'b0, 0, 0);

    // Reset: a write presented during reset must not bypass to the outputs.
    #2;
    wr(1'b1, 5, 32'hffff_ffff, 1'b0, 0, 0);
    rd_a(0, 5, 32'h0, 100); rd_a(1, 0, 32'h0, 101); rd_b(0, 5, 32'h0, 102);
    push(2, 0, 32'h0, 103);
    tick();
    wr(1'b0, 0, 0, 1'b0, 0, 0);
    tick();
    rst = 1'b0;
    for (int a = 0; a < 32; a += 2) begin
      rd_a(0, a, 32'h0, 110 + a); rd_a(1, a + 1, 32'h0, 111 + a);
      tick();
    end

    // Basic write, bypass, zero register.
    wr(1'b1, 5, 32'habcd_1234, 1'b0, 0, 0);
    rd_a(1, 5, 32'habcd_1234, 200); rd_b(1, 5, 32'h0, 201);
    tick();
    wr(1'b1, 0, 32'hffff_ffff, 1'b0, 0, 0);
    rd_a(0, 5, 32'habcd_1234, 202); rd_b(0, 5, 32'habcd_1234, 203);
    rd_a(1, 0, 32'h0, 204); rd_b(1, 0, 32'h0, 205);
    tick();
    wr(1'b0, 0, 0, 1'b0, 0, 0);
    rd_a(0, 0, 32'h0, 206); rd_b(0, 0, 32'hffff_ffff, 207);
    tick();

    // Same-address collision, then two distinct addresses.
    wr(1'b1, 7, 32'h77, 1'b0, 0, 0);
    tick();
    wr(1'b1, 7, 32'h1111_1111, 1'b1, 7, 32'h2222_2222);
    rd_a(0, 7, 32'h2222_2222, 300); rd_b(0, 7, 32'h77, 301);
    tick();
    wr(1'b1, 8, 32'h8888, 1'b1, 9, 32'h9999);
    rd_a(0, 7, 32'h2222_2222, 302); rd_b(0, 7, 32'h2222_2222, 303);
    rd_a(1, 8, 32'h8888, 304); rd_b(1, 8, 32'h0, 305);
    tick();
    wr(1'b0, 0, 0, 1'b0, 0, 0);
    rd_a(0, 8, 32'h8888, 306); rd_a(1, 9, 32'h9999, 307);
    tick();

    // Fill, then sequenced clear with dropped writes and an ignored second clear.
    for (int i = 1; i < 32; i++) begin
      wr(1'b1, i, i, 1'b0, 0, 0);
      tick();
    end
    wr(1'b0, 0, 0, 1'b0, 0, 0);
    clear = 1'b1;
    push(2, 0, 32'h0, 400);
    tick();
    for (int k = 0; k <= 32; k++) begin
      clear = (k == 10);
      if (k == 3) wr(1'b1, 20, 32'hdead_beef, 1'b1, 3, 32'hdead_beef);
      else        wr(1'b0, 0, 0, 1'b0, 0, 0);
      push(2, 0, (k < 32) ? 32'h1 : 32'h0, 410 + k);
      rd_a(0, (k == 0) ? 0 : k - 1, 32'h0, 450 + k);
      rd_a(1, (k > 31) ? 31 : k, (k == 0 || k > 31) ? 32'h0 : k, 500 + k);
      tick();
    end
    clear = 1'b0;
    rd_a(0, 20, 32'h0, 540); rd_a(1, 3, 32'h0, 541);
    tick();

    // Reset during clear aborts the engine and zeroes everything.
    wr(1'b1, 20, 32'h44, 1'b1, 25, 32'h66);
    tick();
    wr(1'b0, 0, 0, 1'b0, 0, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int j = 0; j < 8; j++) tick();
    rd_a(0, 20, 32'h44, 600); rd_a(1, 25, 32'h66, 601); push(2, 0, 32'h1, 602);
    tick();
    rst = 1'b1;
    rd_a(0, 20, 32'h0, 603); rd_a(1, 25, 32'h0, 604); push(2, 0, 32'h0, 605);
    tick();
    rst = 1'b0;
    wr(1'b1, 20, 32'h5555, 1'b0, 0, 0);
    tick();
    wr(1'b0, 0, 0, 1'b0, 0, 0);
    rd_a(0, 20, 32'h5555, 606); rd_a(1, 25, 32'h0, 607); push(2, 0, 32'h0, 608);
    tick();

    // Non-power-of-two depth and four parallel read ports.
    wr(1'b1, 30, 32'h3030_3030, 1'b1, 1, 32'h1);
    tick();
    wr(1'b1, 2, 32'h2, 1'b1, 3, 32'h3);
    rd_b(0, 30, 32'h0, 700); rd_a(0, 30, 32'h3030_3030, 701);
    tick();
    wr(1'b1, 23, 32'h17, 1'b0, 0, 0);
    tick();
    wr(1'b0, 0, 0, 1'b0, 0, 0);
    rd_b(0, 1, 32'h1, 702); rd_b(1, 2, 32'h2, 703);
    rd_b(2, 3, 32'h3, 704); rd_b(3, 23, 32'h17, 705);
    tick();
    rd_b(0, 30, 32'h0, 706); rd_b(1, 31, 32'h0, 707);
    tick();

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
